// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, board typedefs and a
// small range helper used by the sync decoders.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [11:0]      tile_t;
  typedef tile_t [3:0][3:0] board_t;
  typedef logic [9:0]       coord_t;

  // Inclusive range test on raster coordinates.
  function automatic logic in_span(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Video-side bundle: pixel clock, syncs, blanking and raster position.
// The controller drives it (master); DAC and painter observe it (slave).
interface vga_if;
  import vga_pkg::*;

  logic   vga_clk;
  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   sync_n;
  coord_t x;
  coord_t y;
  logic   frame_start;

  modport master (
    output vga_clk, hsync, vsync, blank_n, sync_n, x, y, frame_start
  );

  modport slave (
    input vga_clk, hsync, vsync, blank_n, sync_n, x, y, frame_start
  );

endinterface

// File: rtl/vga_controller.sv
// VGA timing generator. clk is halved into a pixel enable; h/v raster counters
// run on that enable and every output is registered one clk behind them.
// Game state and board are snapshotted on entry to vertical blank so the
// painter sees a stable picture for the whole frame.
module vga_controller #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      game_state_in,
  input  vga_pkg::board_t matrix_in,
  output logic [1:0]      game_state_out,
  output vga_pkg::board_t matrix_out,
  vga_if.master           vga
);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_CAP    = 10'(V_ACTIVE - 1);

  logic       pix_en_p0;
  logic [9:0] h_cnt_p0;
  logic [9:0] v_cnt_p0;
  logic       wrap_p0;
  logic       h_wrap;
  logic       v_wrap;
  logic       cap_edge;

  assign h_wrap   = (h_cnt_p0 == H_LAST);
  assign v_wrap   = (v_cnt_p0 == V_LAST);
  // Last pixel of the last visible line: next pixel enters vertical blank.
  assign cap_edge = pix_en_p0 && h_wrap && (v_cnt_p0 == V_CAP);

  // ---- stage p0: pixel enable and raster counters ----

  // Pixel enable toggles every clk, giving one pixel per two clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_p0 <= 1'b0;
    end else begin
      pix_en_p0 <= ~pix_en_p0;
    end
  end

  // Column counter steps per pixel; line counter steps only on column wrap.
  // wrap_p0 marks the first clk at (0,0) after a full frame, never after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      wrap_p0  <= 1'b0;
    end else begin
      wrap_p0 <= pix_en_p0 && h_wrap && v_wrap;
      if (pix_en_p0) begin
        if (h_wrap) begin
          h_cnt_p0 <= '0;
          v_cnt_p0 <= v_wrap ? '0 : v_cnt_p0 + 10'd1;
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 10'd1;
        end
      end
    end
  end

  // ---- stage p1: registered video outputs, one clk behind the counters ----

  // Decode syncs and blanking from the counters and register them with x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.vga_clk     <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.blank_n     <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.vga_clk     <= pix_en_p0;
      vga.x           <= h_cnt_p0;
      vga.y           <= v_cnt_p0;
      vga.hsync       <= ~vga_pkg::in_span(h_cnt_p0, HS_FIRST, HS_LAST);
      vga.vsync       <= ~vga_pkg::in_span(v_cnt_p0, VS_FIRST, VS_LAST);
      vga.blank_n     <= (h_cnt_p0 < H_ACT_C) && (v_cnt_p0 < V_ACT_C);
      vga.frame_start <= wrap_p0;
    end
  end

  // Composite sync is unused by the DAC.
  assign vga.sync_n = 1'b0;

  // Snapshot the live game inputs on entry to vertical blank; hold all frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_state_out <= '0;
      matrix_out     <= '0;
    end else if (cap_edge) begin
      game_state_out <= game_state_in;
      matrix_out     <= matrix_in;
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller. Horizontal timing is the real 800-pixel
// line; vertical timing is shortened to 12 lines (8 active, FP 1, sync 2, BP 1)
// so several frames fit in a short run. Sync lines are therefore 9..10, the
// snapshot edge is (799,7), one frame is 9600 pixels = 19200 clk.
module tb_vga_controller;

  typedef struct {
    logic            vga_clk;
    logic            hsync;
    logic            vsync;
    logic            blank_n;
    logic            frame_start;
    logic [9:0]      x;
    logic [9:0]      y;
    logic [1:0]      gs;
    vga_pkg::board_t board;
    bit              hand_en;
    logic [1:0]      hand_gs;
    logic [11:0]     hand_m00;
    int              n;
  } exp_t;

  localparam int FRAME_PIX = 9600;
  localparam int CAP_PIX   = 6399;
  localparam int IT_MAX    = 60000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      gs_drv;
  vga_pkg::board_t mat_drv;
  logic [1:0]      gs_out;
  vga_pkg::board_t mat_out;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  bit   mid_phase = 1'b0;

  // monitor measurement state
  int mcyc = 0;
  int ls_last = -1;
  int blank_cnt = 0;
  int hs_fall = 0;
  int hs_len = 0;
  int lines_chk = 0;
  int vs_fall = 0;
  bit vs_done = 1'b0;
  int fs_last = 0;
  int fs_cnt = 0;
  int fs_post = 0;
  int y_max = 0;
  logic [9:0] x_prev = '0;
  logic [9:0] y_prev = '0;
  logic hs_prev = 1'b1;
  logic vs_prev = 1'b1;

  always #5 clk = ~clk;

  vga_if vif ();

  vga_controller #(
    .V_ACTIVE(8),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_state_in (gs_drv),
    .matrix_in     (mat_drv),
    .game_state_out(gs_out),
    .matrix_out    (mat_out),
    .vga           (vif)
  );

  task automatic chk(input string name, input int nn, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0d: got %0h want %0h", name, nn, got, want);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, mcyc, got, want);
    end
  endtask

  // Expected outputs after clk edge nn counted from reset release (0 = reset).
  function automatic exp_t calc(input int nn, input logic [1:0] gs, input vga_pkg::board_t b);
    exp_t r;
    int p;
    int h;
    int v;
    r.gs       = gs;
    r.board    = b;
    r.hand_en  = 1'b0;
    r.hand_gs  = '0;
    r.hand_m00 = '0;
    r.n        = nn;
    if (nn == 0) begin
      r.vga_clk     = 1'b0;
      r.hsync       = 1'b1;
      r.vsync       = 1'b1;
      r.blank_n     = 1'b0;
      r.frame_start = 1'b0;
      r.x           = '0;
      r.y           = '0;
    end else begin
      p = (nn - 1) / 2;
      h = p % 800;
      v = (p / 800) % 12;
      r.vga_clk     = ((nn - 1) % 2) == 1;
      r.hsync       = !((h >= 656) && (h <= 751));
      r.vsync       = !((v >= 9) && (v <= 10));
      r.blank_n     = (h < 640) && (v < 8);
      r.frame_start = ((nn % 2) == 1) && (p > 0) && ((p % FRAME_PIX) == 0);
      r.x           = 10'(h);
      r.y           = 10'(v);
    end
    return r;
  endfunction

  // Driver: applies stimulus just after each posedge and queues the expectation.
  initial begin
    exp_t            e;
    int              n;
    int              rst_cnt;
    bit              mid_done;
    bit              stop;
    logic [1:0]      m_gs;
    vga_pkg::board_t m_board;
    n = 0;
    rst_cnt = 0;
    mid_done = 1'b0;
    stop = 1'b0;
    m_gs = '0;
    m_board = '0;
    gs_drv = 2'b00;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_drv[i][j] = 12'h100 + 12'(i * 4 + j);
    mat_drv[0][0] = 12'd5;
    rst_n = 1'b0;
    for (int it = 0; it < IT_MAX && !stop; it++) begin
      @(posedge clk);
      if (rst_n) n++;
      if (rst_n && (n > 0) && ((n % 2) == 0) && ((((n - 1) / 2) % FRAME_PIX) == CAP_PIX)) begin
        m_gs    = gs_drv;
        m_board = mat_drv;
      end
      #1;
      if (it == 5) rst_n = 1'b1;
      if (!mid_done) begin
        if (n == 12799) gs_drv = 2'b10;
        if (n == 24001) begin
          mat_drv[0][0] = 12'd2;
          mat_drv[3][3] = 12'hABC;
          gs_drv        = 2'b01;
        end
        if (n == 46401) begin
          rst_n     = 1'b0;
          rst_cnt   = 0;
          mid_done  = 1'b1;
          mid_phase = 1'b1;
        end
      end else if (!rst_n) begin
        rst_cnt++;
        if (rst_cnt == 3) rst_n = 1'b1;
      end else if (n == 3400) begin
        stop = 1'b1;
      end
      if (!rst_n) begin
        n       = 0;
        m_gs    = '0;
        m_board = '0;
      end
      e = calc(n, m_gs, m_board);
      if (!mid_done) begin
        case (n)
          12799: begin e.hand_en = 1'b1; e.hand_gs = 2'b00; e.hand_m00 = 12'd0; end
          12800: begin e.hand_en = 1'b1; e.hand_gs = 2'b10; e.hand_m00 = 12'd5; end
          31999: begin e.hand_en = 1'b1; e.hand_gs = 2'b10; e.hand_m00 = 12'd5; end
          32000: begin e.hand_en = 1'b1; e.hand_gs = 2'b01; e.hand_m00 = 12'd2; end
          default: ;
        endcase
      end
      sb_q.push_back(e);
    end
    if (!stop) chk_i("run_budget", 0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk_i("frame_start_count", fs_cnt, 2);
    chk_i("frame_start_after_reset", fs_post, 0);
    chk_i("lines_measured", lines_chk, 2);
    chk_i("vsync_measured", int'(vs_done), 1);
    chk_i("queue_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Monitor: pops one expectation per clk on the falling edge and compares,
  // then measures line/frame timing from the observed waveforms.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mcyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("timing", e.n,
            256'({vif.vga_clk, vif.hsync, vif.vsync, vif.blank_n, vif.sync_n, vif.frame_start}),
            256'({e.vga_clk, e.hsync, e.vsync, e.blank_n, 1'b0, e.frame_start}));
        chk("position", e.n, 256'({vif.x, vif.y}), 256'({e.x, e.y}));
        chk("snapshot", e.n, 256'({gs_out, mat_out}), 256'({e.gs, e.board}));
        if (e.hand_en)
          chk("snap_directed", e.n, 256'({gs_out, mat_out[0][0]}), 256'({e.hand_gs, e.hand_m00}));
      end
      if (rst_n && !mid_phase) begin
        if (vif.y > y_max) y_max = int'(vif.y);
        if (hs_prev && !vif.hsync) hs_fall = mcyc;
        if (!hs_prev && vif.hsync) hs_len = mcyc - hs_fall;
        if ((vif.x == 10'd0) && (x_prev == 10'd799)) begin
          if ((ls_last >= 0) && (lines_chk < 2)) begin
            chk_i("line_period", mcyc - ls_last, 1600);
            chk_i("blank_n_high", blank_cnt, 1280);
            chk_i("hsync_offset", hs_fall - ls_last, 1312);
            chk_i("hsync_width", hs_len, 192);
            lines_chk++;
          end
          ls_last   = mcyc;
          blank_cnt = 0;
        end
        if (vif.blank_n) blank_cnt++;
        if (!vs_done && vs_prev && !vif.vsync) begin
          vs_fall = mcyc;
          chk_i("vsync_first_line", int'(vif.y), 9);
        end
        if (!vs_done && !vs_prev && vif.vsync) begin
          chk_i("vsync_width", mcyc - vs_fall, 3200);
          chk_i("vsync_last_line", int'(y_prev), 10);
          vs_done = 1'b1;
        end
      end
      if (vif.frame_start) begin
        if (mid_phase) begin
          fs_post++;
        end else begin
          fs_cnt++;
          chk_i("frame_start_xy", int'({vif.x, vif.y}), 0);
          if (fs_cnt == 1) chk_i("y_max", y_max, 11);
          else chk_i("frame_period", mcyc - fs_last, 19200);
          fs_last = mcyc;
        end
      end
      x_prev  = vif.x;
      y_prev  = vif.y;
      hs_prev = vif.hsync;
      vs_prev = vif.vsync;
    end
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal front porch, sync and back porch in pixels (H_TOTAL = 800).
REQ-003 SHALL have parameter V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical timing in lines (V_TOTAL = 525).
REQ-004 SHALL have port clk, input, 1, 50 MHz system clock; the block uses one clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port game_state_in, input, 2, live game state from the game logic.
REQ-007 SHALL have port matrix_in, input, 12 x [3:0][3:0], live board tile values.
REQ-008 SHALL have port vga_clk, output, 1, 25 MHz pixel clock to the DAC.
REQ-009 SHALL have ports hsync and vsync, output, 1 each, active-low sync pulses.
REQ-010 SHALL have port blank_n, output, 1, high only inside the 640x480 active area.
REQ-011 SHALL have port sync_n, output, 1, tied to 0.
REQ-012 SHALL have ports x and y, output, 10 each, current pixel column and line.
REQ-013 SHALL have port frame_start, output, 1, one-clk pulse at the first pixel of each frame.
REQ-014 SHALL have ports game_state_out (2) and matrix_out (12 x [3:0][3:0]), outputs, frame-stable snapshots consumed by the painter.

Function
REQ-015 SHALL generate an internal pix_en that toggles every clk, starting at 0 after reset; vga_clk SHALL equal the registered pix_en.
REQ-016 SHALL advance h_cnt on clk edges where pix_en=1, wrapping from H_TOTAL-1 to 0.
REQ-017 SHALL increment v_cnt only when h_cnt wraps, wrapping from V_TOTAL-1 to 0.
REQ-018 SHALL register all outputs; x, y, hsync, vsync and blank_n SHALL reflect the counter values with exactly one clk of latency.
REQ-019 SHALL drive x = h_cnt and y = v_cnt at all times, including during blanking.
REQ-020 SHALL drive hsync = 0 for h_cnt in [656, 751]; it SHALL be 1 otherwise.
REQ-021 SHALL drive vsync = 0 for v_cnt in [490, 491]; it SHALL be 1 otherwise.
REQ-022 SHALL drive blank_n = 1 iff h_cnt < 640 and v_cnt < 480.
REQ-023 SHALL pulse frame_start for one clk when both counters wrap to (0, 0).
REQ-024 SHALL capture game_state_in and matrix_in into game_state_out and matrix_out on the pix_en edge where (h_cnt, v_cnt) = (799, 479), i.e. entry to vertical blank.
REQ-025 SHALL hold the snapshots constant for the rest of the frame; input changes during the active area SHALL have no visible effect.
REQ-026 SHALL produce a frame period of 840000 clk cycles and a line period of 1600 clk cycles.

Reset
REQ-027 SHALL, while rst_n = 0, set pix_en, vga_clk, h_cnt, v_cnt, x, y, blank_n, frame_start, game_state_out and matrix_out to 0, and hsync and vsync to 1, regardless of clk.
REQ-028 SHALL, on rst_n deassertion mid-frame, restart timing from (0, 0) and not emit frame_start until the first wrap.

Structure
REQ-029 SHALL take the timing constants (H_* and V_* values, H_TOTAL, V_TOTAL) and the board typedef (tile_t = 12 bits, board_t = tile_t [3:0][3:0]) from the shared package vga_pkg.
REQ-030 SHALL be a single module with no sub-modules; a sub-module for the counter pair is not required.

Verification
REQ-031 SHALL check reset: hold rst_n = 0 for 5 clk -> hsync = vsync = 1, x = y = 0, blank_n = 0, vga_clk = 0.
REQ-032 SHALL check line timing: run 2 lines -> hsync low for exactly 192 clk starting 1312 clk after the line start, line period 1600 clk, blank_n high for 1280 clk per line.
REQ-033 SHALL check frame timing: run 1 frame -> vsync low for 3200 clk on lines 490-491, frame_start pulses exactly once every 840000 clk, and y reaches a maximum of 524.
REQ-034 SHALL check snapshot timing: set matrix_in[0][0] = 12'd2 at line 100 -> matrix_out[0][0] stays at its old value until (799, 479), then equals 2.
REQ-035 SHALL check the simultaneous case: change game_state_in 2'b00 -> 2'b10 on the same clk as the capture edge -> game_state_out = 2'b10 on the following clk.
REQ-036 SHALL check mid-frame reset: assert rst_n = 0 at line 300 for 3 clk -> counters restart at (0, 0), with no spurious frame_start and no glitch on sync.
